// File: rtl/stopwatch_ctrl_if.sv
// Button/time/control bundle between the stopwatch front-end and its surroundings.
// slave: the control block; master: whoever drives the buttons and time word.
interface stopwatch_ctrl_if #(
  parameter int TIME_W = 27
);
  logic              btn_ss;
  logic              btn_lr;
  logic [TIME_W-1:0] time_in;
  logic              count_en;
  logic              ms_tick;
  logic              clr;
  logic [TIME_W-1:0] disp_time;
  logic [TIME_W-1:0] lap_time;
  logic [1:0]        state;

  modport master (
    output btn_ss, btn_lr, time_in,
    input  count_en, ms_tick, clr, disp_time, lap_time, state
  );

  modport slave (
    input  btn_ss, btn_lr, time_in,
    output count_en, ms_tick, clr, disp_time, lap_time, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button conditioning, run/pause/lap/clear FSM,
// 1 ms prescaler, lap capture and registered display value.

// One button lane: 2-flop synchronizer, debounce, rising-level press pulse.
module sw_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          acc;
  logic [CW-1:0] cnt;

  // bring the raw level into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[0], raw};
  end

  // accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
  // the press pulse fires on the cycle a 0->1 level is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      acc   <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync[1] != acc) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          acc   <= sync[1];
          cnt   <= '0;
          press <= sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int CLK_DIV         = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIME_W          = 27
) (
  input logic             clk,
  input logic             reset_n,
  stopwatch_ctrl_if.slave bus
);
  localparam int NB = 2;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} st_t;

  logic [NB-1:0]     raw, ev;
  logic              ss, lr;
  st_t               st_q, st_d;
  logic              go_run, do_clr, lap_cap, hold_disp;
  logic              cnt_en_q, clr_q, tick;
  logic [PW-1:0]     presc;
  logic [TIME_W-1:0] disp_q, lap_q;

  // lane 0 = start/stop, lane 1 = lap/reset
  assign raw = {bus.btn_lr, bus.btn_ss};

  sw_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NB-1:0] (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (raw),
    .press  (ev)
  );

  assign ss = ev[0];
  assign lr = ev[1];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= IDLE;
    else          st_q <= st_d;
  end

  // next state; start/stop takes priority when both events land together
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (ss) st_d = RUN;
      RUN:     if (ss) st_d = PAUSE; else if (lr) st_d = LAP;
      LAP:     if (ss) st_d = PAUSE; else if (lr) st_d = RUN;
      PAUSE:   if (ss) st_d = RUN;   else if (lr) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  assign go_run    = (st_q == IDLE)  && (st_d == RUN);
  assign do_clr    = (st_q == PAUSE) && (st_d == IDLE);
  assign lap_cap   = (st_q == RUN)   && (st_d == LAP);
  assign hold_disp = (st_q == LAP)   && (st_d == LAP);

  // registered control outputs, lap capture and display freeze
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_en_q <= 1'b0;
      clr_q    <= 1'b0;
      lap_q    <= '0;
      disp_q   <= '0;
    end else begin
      cnt_en_q <= (st_d == RUN) || (st_d == LAP);
      clr_q    <= do_clr;
      if (lap_cap)     lap_q <= bus.time_in;
      else if (do_clr) lap_q <= '0;
      // entering LAP loads the same sample that lap_time captures
      if (!hold_disp)  disp_q <= bus.time_in;
    end
  end

  assign tick = cnt_en_q && (presc == PW'(CLK_DIV - 1));

  // ms prescaler: frozen while paused so a resume keeps the partial ms
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              presc <= '0;
    else if (clr_q || go_run)  presc <= '0;
    else if (cnt_en_q)         presc <= tick ? '0 : presc + 1'b1;
  end

  assign bus.state     = st_q;
  assign bus.count_en  = cnt_en_q;
  assign bus.ms_tick   = tick;
  assign bus.clr       = clr_q;
  assign bus.disp_time = disp_q;
  assign bus.lap_time  = lap_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CLK_DIV=4, DEBOUNCE_CYCLES=3.
// Inputs change on the falling edge; scheduled expectations are compared
// 2 time units after the rising edge they are due on.
module tb_stopwatch_ctrl;
  localparam int TW = 27;

  logic clk;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   ecount = 0;
  int   S;
  logic [TW-1:0] prev;

  stopwatch_ctrl_if #(.TIME_W(TW)) sif();

  stopwatch_ctrl #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3), .TIME_W(TW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         due;
    logic [3:0] msk;   // 0 state, 1 count_en, 2 ms_tick, 3 clr
    logic [1:0] st;
    logic       en;
    logic       tk;
    logic       cl;
  } exp_t;

  typedef struct {
    string      nm;
    logic       ss;
    logic       lr;
    logic [1:0] st;
    logic       en;
    logic       cl;
  } vec_t;

  exp_t q[$];
  vec_t vt[10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(string nm, int due, logic [3:0] msk, logic [1:0] st,
                               logic en, logic tk, logic cl);
    exp_t e;
    e.nm = nm; e.due = due; e.msk = msk; e.st = st; e.en = en; e.tk = tk; e.cl = cl;
    q.push_back(e);
  endfunction

  // scoreboard: compare every entry due on this edge
  initial begin
    forever begin
      @(posedge clk);
      ecount++;
      #2;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due <= ecount) begin
          if (q[i].due != ecount) chk({q[i].nm, ".late"}, 32'(ecount), 32'(q[i].due));
          if (q[i].msk[0]) chk({q[i].nm, ".state"}, 32'(sif.state), 32'(q[i].st));
          if (q[i].msk[1]) chk({q[i].nm, ".count_en"}, 32'(sif.count_en), 32'(q[i].en));
          if (q[i].msk[2]) chk({q[i].nm, ".ms_tick"}, 32'(sif.ms_tick), 32'(q[i].tk));
          if (q[i].msk[3]) chk({q[i].nm, ".clr"}, 32'(sif.clr), 32'(q[i].cl));
          q.delete(i);
        end
      end
    end
  end

  // advance n falling edges; time_in acts as a free-running counter
  task automatic nclk(int n);
    repeat (n) begin
      @(negedge clk);
      prev = sif.time_in;
      sif.time_in = sif.time_in + 1'b1;
    end
  endtask

  // full press/release of the given buttons; new state lands 6 edges in
  task automatic press(string nm, logic ss, logic lr, logic [1:0] old_st,
                       logic [1:0] st, logic en, logic cl);
    int b;
    b = ecount;
    sif.btn_ss = ss;
    sif.btn_lr = lr;
    push({nm, "_pre"}, b + 5, 4'b0001, old_st, 1'b0, 1'b0, 1'b0);
    push(nm, b + 6, 4'b1011, st, en, 1'b0, cl);
    push({nm, "_post"}, b + 7, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b0);
    nclk(8);
    sif.btn_ss = 1'b0;
    sif.btn_lr = 1'b0;
    nclk(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    logic [1:0] old;

    vt[0] = '{"lr_idle", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[1] = '{"start",   1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
    vt[2] = '{"pause",   1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
    vt[3] = '{"resume",  1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
    vt[4] = '{"lap",     1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
    vt[5] = '{"lap_ss",  1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
    vt[6] = '{"clear",   1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    vt[7] = '{"start2",  1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
    vt[8] = '{"both",    1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
    vt[9] = '{"clear2",  1'b0, 1'b1, 2'b00, 1'b0, 1'b1};

    // reset: everything zero even with a live time word
    sif.btn_ss = 1'b0;
    sif.btn_lr = 1'b0;
    sif.time_in = 27'h5A5;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.state", 32'(sif.state), 32'd0);
    chk("rst.count_en", 32'(sif.count_en), 32'd0);
    chk("rst.ms_tick", 32'(sif.ms_tick), 32'd0);
    chk("rst.clr", 32'(sif.clr), 32'd0);
    chk("rst.disp", 32'(sif.disp_time), 32'd0);
    chk("rst.lap", 32'(sif.lap_time), 32'd0);
    reset_n = 1'b1;
    nclk(4);
    chk("idle.disp_track", 32'(sif.disp_time), 32'(prev));

    // bounce: 2-cycle pulses never survive a 3-cycle debounce
    b = ecount;
    for (int e = b + 1; e <= b + 20; e++) push("bounce", e, 4'b0011, 2'b00, 1'b0, 1'b0, 1'b0);
    sif.btn_ss = 1'b1; nclk(2);
    sif.btn_ss = 1'b0; nclk(2);
    sif.btn_ss = 1'b1; nclk(2);
    sif.btn_ss = 1'b0; nclk(14);

    // table of press/release vectors across every FSM arc
    old = 2'b00;
    for (int i = 0; i < 10; i++) begin
      press(vt[i].nm, vt[i].ss, vt[i].lr, old, vt[i].st, vt[i].en, vt[i].cl);
      old = vt[i].st;
    end
    chk("tbl.lap_cleared", 32'(sif.lap_time), 32'd0);

    // debounced start timing and tick cadence
    b = ecount;
    sif.btn_ss = 1'b1;
    push("go_pre", b + 5, 4'b0011, 2'b00, 1'b0, 1'b0, 1'b0);
    push("go", b + 6, 4'b0011, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int e = b + 1; e <= b + 18; e++)
      push("go_tick", e, 4'b0100, 2'b00, 1'b0, (e >= b + 6) && ((e - b - 6) % 4 == 3), 1'b0);
    S = b + 6;
    nclk(10);
    sif.btn_ss = 1'b0;
    nclk(8);

    // lap freeze: event edge samples time_in = 0x123
    sif.btn_lr = 1'b1;
    sif.time_in = 27'h11E;
    nclk(5);
    chk("lap.pre_state", 32'(sif.state), 32'd1);
    nclk(1);
    chk("lap.state", 32'(sif.state), 32'd3);
    chk("lap.lap_time", 32'(sif.lap_time), 32'h123);
    chk("lap.disp", 32'(sif.disp_time), 32'h123);
    nclk(2);
    sif.btn_lr = 1'b0;
    nclk(3);
    chk("lap.disp_hold", 32'(sif.disp_time), 32'h123);
    chk("lap.count_en", 32'(sif.count_en), 32'd1);
    nclk(5);
    sif.btn_lr = 1'b1;
    nclk(6);
    chk("unlap.state", 32'(sif.state), 32'd1);
    chk("unlap.disp", 32'(sif.disp_time), 32'(prev));
    chk("unlap.lap_keep", 32'(sif.lap_time), 32'h123);
    nclk(2);
    sif.btn_lr = 1'b0;
    nclk(8);

    // pause with the prescaler at 2, then resume keeping the partial ms
    while (((ecount + 6 - S) % 4) != 2) nclk(1);
    b = ecount;
    sif.btn_ss = 1'b1;
    push("ps_pre", b + 5, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int e = b + 6; e <= b + 14; e++) push("paused", e, 4'b0111, 2'b10, 1'b0, 1'b0, 1'b0);
    nclk(8);
    sif.btn_ss = 1'b0;
    nclk(8);
    b = ecount;
    sif.btn_ss = 1'b1;
    push("rs", b + 6, 4'b0011, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int e = b + 1; e <= b + 16; e++)
      push("rs_tick", e, 4'b0100, 2'b00, 1'b0, (e >= b + 6) && ((e - b - 6) % 4 == 1), 1'b0);
    nclk(8);
    sif.btn_ss = 1'b0;
    nclk(8);

    // clear from pause: clr exactly one cycle, lap zeroed
    press("pause2", 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0);
    b = ecount;
    sif.btn_lr = 1'b1;
    push("clr_st", b + 6, 4'b0011, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int e = b + 1; e <= b + 12; e++)
      push("clr_pulse", e, 4'b1000, 2'b00, 1'b0, 1'b0, e == b + 6);
    nclk(6);
    chk("clr.lap", 32'(sif.lap_time), 32'd0);
    nclk(2);
    sif.btn_lr = 1'b0;
    nclk(8);
    press("idle_lr2", 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    chk("clr.disp_track", 32'(sif.disp_time), 32'(prev));

    // simultaneous presses: start/stop wins, lap untouched
    press("c_start", 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0);
    sif.time_in = 27'h451;
    press("c_lap", 1'b0, 1'b1, 2'b01, 2'b11, 1'b1, 1'b0);
    chk("c_lap.lap_time", 32'(sif.lap_time), 32'h456);
    press("c_unlap", 1'b0, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
    press("c_both", 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0);
    chk("c_both.lap_time", 32'(sif.lap_time), 32'h456);
    press("c_resume", 1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0);

    // asynchronous reset between edges while running
    nclk(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.state", 32'(sif.state), 32'd0);
    chk("arst.count_en", 32'(sif.count_en), 32'd0);
    chk("arst.ms_tick", 32'(sif.ms_tick), 32'd0);
    chk("arst.clr", 32'(sif.clr), 32'd0);
    chk("arst.disp", 32'(sif.disp_time), 32'd0);
    chk("arst.lap", 32'(sif.lap_time), 32'd0);
    nclk(2);
    reset_n = 1'b1;
    nclk(3);

    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control front-end for the stopwatch timekeeping counter.
- Conditions two raw push-buttons: start/stop and lap/reset.
- Runs the run/pause/lap/clear state machine and generates the 1 ms count-enable tick.
- Captures lap times and drives the registered display value. Sits between board buttons and the {h,m,s,ms} counter datapath.

Parameters:
- CLK_DIV, 100000, clk cycles per ms_tick (100 MHz -> 1 kHz).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level (10 ms).
- TIME_W, 27, width of packed time word {h[4:0],m[5:0],s[5:0],ms[9:0]}.

Ports:
- clk  input  1  system clock; the block's only clock.
- reset_n  input  1  asynchronous, active-low reset.
- btn_ss  input  1  raw start/stop button, asynchronous to clk, may bounce.
- btn_lr  input  1  raw lap/reset button, asynchronous to clk, may bounce.
- time_in  input  TIME_W  live time word from the counter datapath.
- count_en  output  1  high while the counter must run.
- ms_tick  output  1  one-cycle increment strobe to the counter.
- clr  output  1  one-cycle synchronous clear strobe to the counter.
- disp_time  output  TIME_W  value to display, registered.
- lap_time  output  TIME_W  last captured lap value.
- state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0, all of the following are 0 without a clk edge:
  - outputs: state=IDLE, count_en, ms_tick, clr, disp_time, lap_time;
  - internal: synchronizer flops, debounce counters, accepted levels, prescaler.
- Button conditioning, per button independently:
  - 2-flop synchronizer.
  - Debounce counter increments while synced level != accepted level. It clears whenever the levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level updates and the counter clears.
  - Accepted 0->1 transition = one-cycle press event. Releases generate no event.
  - Raw edge held stable -> FSM state/output change visible exactly DEBOUNCE_CYCLES+3 clk edges after the first edge sampling the new raw level.
  - Button held at reset release is accepted as a press after debounce.
- FSM transitions (ss = start/stop event, lr = lap/reset event):
  - IDLE: ss -> RUN, prescaler cleared to 0. lr ignored.
  - RUN: ss -> PAUSE. lr -> LAP, lap_time<=time_in and disp frozen at that same value.
  - LAP: counting continues. lr -> RUN with disp unfrozen. ss -> PAUSE with disp unfrozen.
  - PAUSE: ss -> RUN with prescaler retained. lr -> IDLE, clr=1 for exactly one cycle, lap_time<=0.
  - ss and lr in the same cycle: ss wins, lr dropped.
- count_en = registered, 1 in RUN and LAP, 0 otherwise.
- Prescaler:
  - Counts 0..CLK_DIV-1, advances only while count_en=1.
  - ms_tick=1 in the cycle the prescaler equals CLK_DIV-1 with count_en=1; prescaler then wraps to 0.
  - Value holds across PAUSE, so resume keeps the partial ms.
  - Cleared by clr and on IDLE->RUN.
- disp_time:
  - Not frozen: disp_time<=time_in every cycle (1-cycle latency).
  - Frozen (LAP): holds the captured lap value.
  - IDLE after clear: tracks time_in, which the counter has zeroed.
- Overflow and wrap of time_in are the datapath's responsibility; this block passes values through unmodified.

Test Plan:
- Use CLK_DIV=4, DEBOUNCE_CYCLES=3 throughout.
- Debounced start: reset, btn_ss=1 held 10 cycles -> count_en and state=01 rise 6 edges after the first sampling edge. ms_tick pulses on the 4th, 8th, 12th... count_en cycles.
- Bounce rejection: in IDLE, btn_ss toggles 1,0,1,0 with 2-cycle pulses, then returns to 0 -> no event; state stays 00, count_en stays 0.
- Lap freeze:
  - RUN, bench increments time_in each cycle; press btn_lr; event cycle sees time_in=0x0000123 -> lap_time=disp_time=0x0000123 and state=11.
  - disp holds while time_in advances; count_en stays 1.
  - Second lr press -> state=01, disp_time equals time_in from the previous cycle.
- Pause/resume: pause when prescaler=2 -> ms_tick stops, count_en=0. Resume -> first ms_tick on the 2nd count_en cycle, then every 4.
- Clear: PAUSE, press btn_lr -> state=00, clr high exactly one cycle, lap_time=0. Further btn_lr presses in IDLE -> no change.
- Conflict and reset:
  - In RUN, btn_ss and btn_lr rise on the same cycle -> state=10, lap_time unchanged.
  - Drop reset_n mid-RUN between clk edges -> all outputs 0 and state=00 immediately.
